// File: rtl/web_mode_dispatcher.sv
// rtl/web_mode_dispatcher.sv - web shooter mode dispatcher with fluid/tracer/energy accounting
module web_mode_dispatcher #(
    parameter int FLUID_W      = 4,
    parameter int FLUID_MAX    = 15,
    parameter int TRACER_W     = 3,
    parameter int TRACER_MAX   = 6,
    parameter int ENERGY_W     = 8,
    parameter int ENERGY_MAX   = 200,
    parameter int TASER_E      = 50,
    parameter int RECHARGE_CYC = 16,
    parameter int COOL_CYC     = 4,
    parameter int RELOAD_CYC   = 8,
    parameter logic [8*FLUID_W-1:0] FLUID_COST =
        {4'd0, 4'd0, 4'd3, 4'd1, 4'd4, 4'd2, 4'd1, 4'd1}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic [2:0]          sel,
    input  logic                req_valid,
    output logic                req_ready,
    output logic [7:0]          fire_onehot,
    output logic                done,
    output logic                denied,
    output logic                busy,
    output logic [FLUID_W-1:0]  fluid_level,
    output logic [TRACER_W-1:0] tracer_count,
    output logic [ENERGY_W-1:0] energy_level
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FIRE,
        S_DENY,
        S_COOL,
        S_RELOAD
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           mode_q;
    logic [15:0]          phase_q;
    logic [FLUID_W-1:0]   fluid_q;
    logic [TRACER_W-1:0]  tracer_q;
    logic [ENERGY_W-1:0]  energy_q;
    logic [FLUID_W-1:0]   cost;
    logic                 can_fire;
    logic                 fire_go;
    logic                 reload_go;
    logic                 taser_go;
    logic                 tick;
    logic                 cool_last;
    logic                 reload_last;
    logic [ENERGY_W:0]    e_wide;
    logic [2:0]           sel_mode;

    // sel is wired bit-reversed relative to the mode number
    assign sel_mode = {sel[0], sel[1], sel[2]};
    assign cost     = FLUID_COST[32'(mode_q)*FLUID_W +: FLUID_W];

    assign can_fire = (fluid_q >= cost)
                   && ((mode_q != 3'd4) || (energy_q >= ENERGY_W'(TASER_E)))
                   && ((mode_q != 3'd6) || (tracer_q != '0));

    assign cool_last   = (32'(phase_q) + 32'd1 >= COOL_CYC);
    assign reload_last = (32'(phase_q) + 32'd1 >= RELOAD_CYC);

    always_comb begin
        state_d   = state_q;
        fire_go   = 1'b0;
        reload_go = 1'b0;
        case (state_q)
            S_IDLE:   if (req_valid && arm) state_d = S_CHECK;
            S_CHECK: begin
                if (mode_q == 3'd7) begin
                    state_d = S_RELOAD;
                end else if (can_fire) begin
                    state_d = S_FIRE;
                    fire_go = 1'b1;
                end else begin
                    state_d = S_DENY;
                end
            end
            S_FIRE:   state_d = (mode_q == 3'd7) ? S_IDLE : S_COOL;
            S_DENY:   state_d = S_IDLE;
            S_COOL:   if (cool_last) state_d = S_IDLE;
            S_RELOAD: begin
                if (reload_last) begin
                    state_d   = S_FIRE;
                    reload_go = 1'b1;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    assign taser_go = fire_go && (mode_q == 3'd4);

    generate
        if (RECHARGE_CYC != 0) begin : g_recharge
            logic [15:0] rc_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rc_q <= '0;
                end else if (rc_q == 16'(RECHARGE_CYC - 1)) begin
                    rc_q <= '0;
                end else begin
                    rc_q <= rc_q + 16'd1;
                end
            end
            assign tick = (rc_q == 16'(RECHARGE_CYC - 1));
        end else begin : g_no_recharge
            assign tick = 1'b0;
        end
    endgenerate

    // deduction only happens when energy covers it, so the sum never underflows
    always_comb begin
        e_wide = {1'b0, energy_q} + {{ENERGY_W{1'b0}}, tick}
               - (taser_go ? (ENERGY_W+1)'(TASER_E) : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            phase_q  <= '0;
            fluid_q  <= FLUID_W'(FLUID_MAX);
            tracer_q <= TRACER_W'(TRACER_MAX);
            energy_q <= ENERGY_W'(ENERGY_MAX);
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid && arm) mode_q <= sel_mode;
            if (state_d != state_q) begin
                phase_q <= '0;
            end else if (state_q == S_COOL || state_q == S_RELOAD) begin
                phase_q <= phase_q + 16'd1;
            end
            if (reload_go) begin
                fluid_q <= FLUID_W'(FLUID_MAX);
            end else if (fire_go) begin
                fluid_q <= fluid_q - cost;
            end
            if (fire_go && mode_q == 3'd6) tracer_q <= tracer_q - TRACER_W'(1);
            if (e_wide > (ENERGY_W+1)'(ENERGY_MAX)) begin
                energy_q <= ENERGY_W'(ENERGY_MAX);
            end else begin
                energy_q <= e_wide[ENERGY_W-1:0];
            end
        end
    end

    assign req_ready    = (state_q == S_IDLE) && arm;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FIRE);
    assign denied       = (state_q == S_DENY);
    assign fire_onehot  = (state_q == S_FIRE) ? (8'b1 << mode_q) : 8'b0;
    assign fluid_level  = fluid_q;
    assign tracer_count = tracer_q;
    assign energy_level = energy_q;

endmodule
